// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: session sequencer (tick, gated event pulses, speed, IDLE/COUNTDOWN/RUN/CRASH/GAMEOVER flow).
// Define GAME_PAUSE_EN to add the pauseKey input and the PAUSE state.
module game_flow_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int MAX_SPEED      = 9,
    parameter int ACCEL_FRAMES   = 8,
    parameter int CRASH_SEC      = 2,
    parameter int COUNT_SEC      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       gasKey,
    input  logic       brakeKey,
    input  logic       collision,
    input  logic       fueltank,
`ifdef GAME_PAUSE_EN
    input  logic       pauseKey,
`endif
    input  logic [3:0] fuelLsb,
    input  logic [3:0] fuelMsb,
    output logic       onesec,
    output logic       collisionPulse,
    output logic       fuelPulse,
    output logic [3:0] playerSpeed,
    output logic       datapathResetN,
    output logic [2:0] gameState,
    output logic [3:0] countdownDigit,
    output logic       freeze
);
    localparam int FW = $clog2(FRAMES_PER_SEC + 1);
    localparam int AW = $clog2(ACCEL_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, COUNTDOWN = 3'd1, RUN = 3'd2, CRASH = 3'd3, GAMEOVER = 3'd4, PAUSE = 3'd5
    } state_t;

    state_t state, state_n;
    logic start_q, coll_q, fuel_q;
    logic [FW-1:0] frame_cnt;
    logic [AW-1:0] accel_cnt;
    logic [3:0] crash_cnt, speed, speed_n;
    logic start_e, coll_e, fuel_e, pause_e, empty, adv, step, entering_cd;

    function automatic logic counting(state_t s);
        return s == COUNTDOWN || s == RUN || s == CRASH;
    endfunction

    assign start_e = startKey & ~start_q;
    assign coll_e  = collision & ~coll_q;
    assign fuel_e  = fueltank & ~fuel_q;
    assign empty   = fuelLsb == 4'd0 && fuelMsb == 4'd0;

`ifdef GAME_PAUSE_EN
    logic pause_q;
    assign pause_e = pauseKey & ~pause_q;
    always_ff @(posedge clk) pause_q <= pauseKey;
`else
    assign pause_e = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, GAMEOVER: state_n = start_e ? COUNTDOWN : state;
            COUNTDOWN:      state_n = (onesec && countdownDigit == 4'd1) ? RUN : COUNTDOWN;
            RUN:            state_n = empty ? GAMEOVER : coll_e ? CRASH : pause_e ? PAUSE : RUN;
            CRASH:          state_n = empty ? GAMEOVER : (onesec && crash_cnt == 4'd1) ? RUN : CRASH;
`ifdef GAME_PAUSE_EN
            PAUSE:          state_n = pause_e ? RUN : PAUSE;
`endif
            default:        state_n = IDLE;
        endcase
    end

    // A frame only counts when the flow stays in a ticking state, so pausing freezes the phase.
    assign adv         = startOfFrame && counting(state) && counting(state_n);
    assign step        = startOfFrame && state == RUN && state_n == RUN && accel_cnt == AW'(ACCEL_FRAMES - 1);
    assign entering_cd = state_n == COUNTDOWN && state != COUNTDOWN;
    assign speed_n     = (state_n != RUN && state_n != PAUSE) ? 4'd0 :
                         !step    ? speed :
                         brakeKey ? (speed == 4'd0 ? 4'd0 : speed - 4'd1) :
                         gasKey   ? (speed >= 4'(MAX_SPEED) ? 4'(MAX_SPEED) : speed + 4'd1) : speed;
    assign gameState   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            start_q        <= startKey;
            coll_q         <= collision;
            fuel_q         <= fueltank;
            frame_cnt      <= '0;
            accel_cnt      <= '0;
            crash_cnt      <= 4'd0;
            speed          <= 4'd0;
            onesec         <= 1'b0;
            collisionPulse <= 1'b0;
            fuelPulse      <= 1'b0;
            playerSpeed    <= 4'd0;
            datapathResetN <= 1'b1;
            countdownDigit <= 4'd0;
            freeze         <= 1'b1;
        end else begin
            state          <= state_n;
            start_q        <= startKey;
            coll_q         <= collision;
            fuel_q         <= fueltank;
            frame_cnt      <= entering_cd ? '0 :
                              adv ? (frame_cnt == FW'(FRAMES_PER_SEC - 1) ? '0 : frame_cnt + 1'b1) : frame_cnt;
            onesec         <= adv && frame_cnt == FW'(FRAMES_PER_SEC - 1);
            accel_cnt      <= (state_n == RUN && state != RUN && state != PAUSE) ? '0 :
                              (startOfFrame && state == RUN && state_n == RUN) ?
                              (accel_cnt == AW'(ACCEL_FRAMES - 1) ? '0 : accel_cnt + 1'b1) : accel_cnt;
            crash_cnt      <= (state == RUN && state_n == CRASH) ? 4'(CRASH_SEC) :
                              (state == CRASH && onesec) ? crash_cnt - 4'd1 : crash_cnt;
            countdownDigit <= entering_cd ? 4'(COUNT_SEC) :
                              (state == COUNTDOWN && onesec) ? countdownDigit - 4'd1 : countdownDigit;
            speed          <= speed_n;
            playerSpeed    <= state_n == PAUSE ? 4'd0 : speed_n;
            collisionPulse <= state == RUN && !empty && coll_e;
            fuelPulse      <= state == RUN && !empty && fuel_e;
            datapathResetN <= !entering_cd;
            freeze         <= state_n != RUN;
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed + randomized session bench with a behavioural flow model.
module tb_game_flow_ctrl;
    localparam int FPS = 60, MAXS = 9, ACC = 8, CRS = 2, CNT = 3;
    localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_CRASH = 3, S_GO = 4, S_PAUSE = 5;

    logic clk = 0, reset = 1, startOfFrame = 0, startKey = 0, gasKey = 0, brakeKey = 0;
    logic collision = 0, fueltank = 0, pauseKey = 0;
    logic [3:0] fuelLsb = 4'd5, fuelMsb = 4'd2;
    logic onesec, collisionPulse, fuelPulse, datapathResetN, freeze;
    logic [3:0] playerSpeed, countdownDigit;
    logic [2:0] gameState;

    game_flow_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .startKey(startKey),
        .gasKey(gasKey), .brakeKey(brakeKey), .collision(collision), .fueltank(fueltank),
`ifdef GAME_PAUSE_EN
        .pauseKey(pauseKey),
`endif
        .fuelLsb(fuelLsb), .fuelMsb(fuelMsb), .onesec(onesec), .collisionPulse(collisionPulse),
        .fuelPulse(fuelPulse), .playerSpeed(playerSpeed), .datapathResetN(datapathResetN),
        .gameState(gameState), .countdownDigit(countdownDigit), .freeze(freeze)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int n_ticks = 0, n_crash_ticks = 0, n_cp = 0, n_fp = 0;

    // Expected outputs plus the game-level quantities they derive from.
    int e_state = S_IDLE, e_digit = 0, e_speed = 0, e_saved = 0;
    bit e_one = 0, e_cp = 0, e_fp = 0, e_drn = 1, e_freeze = 1;
    bit p_start, p_coll, p_fuel, p_pause;
    int frames_counted = 0, run_frames = 0, crash_left = 0;

    function automatic bit ticking(int s);
        return s == S_CD || s == S_RUN || s == S_CRASH;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model();
        bit se, ce, fe, pe, empty, new_one;
        int ns;
        if (reset) begin
            e_state = S_IDLE; e_digit = 0; e_speed = 0; e_saved = 0;
            e_one = 0; e_cp = 0; e_fp = 0; e_drn = 1; e_freeze = 1;
            frames_counted = 0; run_frames = 0; crash_left = 0;
            p_start = startKey; p_coll = collision; p_fuel = fueltank; p_pause = pauseKey;
            return;
        end
        se = startKey && !p_start;
        ce = collision && !p_coll;
        fe = fueltank && !p_fuel;
`ifdef GAME_PAUSE_EN
        pe = pauseKey && !p_pause;
`else
        pe = 0;
`endif
        empty = fuelLsb == 0 && fuelMsb == 0;
        ns = e_state;
        if (e_state == S_IDLE || e_state == S_GO) begin
            if (se) ns = S_CD;
        end else if (e_state == S_CD) begin
            if (e_one && e_digit == 1) ns = S_RUN;
        end else if (e_state == S_RUN) begin
            if (empty) ns = S_GO; else if (ce) ns = S_CRASH; else if (pe) ns = S_PAUSE;
        end else if (e_state == S_CRASH) begin
            if (empty) ns = S_GO; else if (e_one && crash_left == 1) ns = S_RUN;
        end else if (e_state == S_PAUSE) begin
            if (pe) ns = S_RUN;
        end
        new_one = 0;
        if (ns == S_CD && e_state != S_CD) frames_counted = 0;
        else if (startOfFrame && ticking(e_state) && ticking(ns)) begin
            frames_counted++;
            new_one = (frames_counted % FPS) == 0;
        end
        if (ns == S_CD && e_state != S_CD) e_digit = CNT;
        else if (e_state == S_CD && e_one) e_digit--;
        if (e_state == S_RUN && ns == S_CRASH) crash_left = CRS;
        else if (e_state == S_CRASH && e_one) crash_left--;
        if (e_state == S_RUN && ns == S_RUN && startOfFrame) begin
            run_frames++;
            if (run_frames % ACC == 0) begin
                if (brakeKey) e_saved = (e_saved > 0) ? e_saved - 1 : 0;
                else if (gasKey) e_saved = (e_saved < MAXS) ? e_saved + 1 : MAXS;
            end
        end else if (ns == S_RUN && e_state != S_RUN && e_state != S_PAUSE) run_frames = 0;
        if (ns != S_RUN && ns != S_PAUSE) e_saved = 0;
        e_speed  = (ns == S_PAUSE) ? 0 : e_saved;
        e_cp     = e_state == S_RUN && !empty && ce;
        e_fp     = e_state == S_RUN && !empty && fe;
        e_drn    = !(ns == S_CD && e_state != S_CD);
        e_freeze = ns != S_RUN;
        e_one    = new_one;
        e_state  = ns;
        p_start = startKey; p_coll = collision; p_fuel = fueltank; p_pause = pauseKey;
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check("gameState", gameState, e_state);
        check("onesec", onesec, e_one);
        check("collisionPulse", collisionPulse, e_cp);
        check("fuelPulse", fuelPulse, e_fp);
        check("playerSpeed", playerSpeed, e_speed);
        check("datapathResetN", datapathResetN, e_drn);
        check("countdownDigit", countdownDigit, e_digit);
        check("freeze", freeze, e_freeze);
        if (onesec) n_ticks++;
        if (onesec && gameState == 3'(S_CRASH)) n_crash_ticks++;
        if (collisionPulse) n_cp++;
        if (fuelPulse) n_fp++;
    endtask

    task automatic frames(int n, bit rnd = 0);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1;
            tick();
            startOfFrame = 0;
            repeat ($urandom_range(2, 4)) begin
                if (rnd) begin
                    if ($urandom_range(0, 29) == 0) collision = ~collision;
                    if ($urandom_range(0, 19) == 0) fueltank = ~fueltank;
                    if ($urandom_range(0, 9) == 0) gasKey = ~gasKey;
                    if ($urandom_range(0, 14) == 0) brakeKey = ~brakeKey;
                    if ($urandom_range(0, 24) == 0) begin
                        fuelLsb = 4'($urandom_range(0, 9));
                        fuelMsb = 4'($urandom_range(1, 9));
                    end
                end
                tick();
            end
        end
    endtask

    task automatic wait_run();
        for (int i = 0; i < 300 && gameState != 3'(S_RUN); i++) frames(1);
        check("wait_run", gameState, S_RUN);
    endtask

    initial begin
        // Reset with startKey held high: no start edge afterwards.
        startKey = 1;
        repeat (3) tick();
        reset = 0;
        repeat (3) tick();
        check("held_start_no_edge", gameState, S_IDLE);
        check("reset_freeze", freeze, 1);
        startKey = 0; tick();
        startKey = 1; tick();
        check("start_drn_low", datapathResetN, 0);
        check("start_digit", countdownDigit, CNT);
        startKey = 0; tick();
        check("drn_one_cycle", datapathResetN, 1);
        frames(179);
        check("cd_179_state", gameState, S_CD);
        check("cd_179_digit", countdownDigit, 1);
        frames(1);
        check("cd_180_run", gameState, S_RUN);
        check("cd_180_digit", countdownDigit, 0);

        gasKey = 1; frames(80);
        check("gas_saturate", playerSpeed, MAXS);
        brakeKey = 1; frames(16);
        check("brake_wins", playerSpeed, 7);
        brakeKey = 0; gasKey = 0;

        n_cp = 0; n_crash_ticks = 0;
        collision = 1; frames(3);
        check("crash_one_pulse", n_cp, 1);
        check("crash_speed0", playerSpeed, 0);
        check("crash_state", gameState, S_CRASH);
        collision = 0; frames(130);
        check("crash_ticks", n_crash_ticks, CRS);
        check("crash_back_run", gameState, S_RUN);

        n_cp = 0; n_fp = 0;
        collision = 1; fueltank = 1; frames(1);
        check("both_cp", n_cp, 1);
        check("both_fp", n_fp, 1);
        fueltank = 0; frames(1);
        fueltank = 1; frames(1);
        check("crash_no_fp", n_fp, 1);
        check("crash_hold", gameState, S_CRASH);
        collision = 0; fueltank = 0;
        wait_run();

        frames(300, 1);
        collision = 0; fueltank = 0; gasKey = 0; brakeKey = 0;
        wait_run();

`ifdef GAME_PAUSE_EN
        brakeKey = 1; frames(80); brakeKey = 0;
        gasKey = 1; frames(40); gasKey = 0;
        check("pause_pre_speed", playerSpeed, 5);
        pauseKey = 1; tick();
        check("pause_state", gameState, S_PAUSE);
        check("pause_speed0", playerSpeed, 0);
        n_ticks = 0; collision = 1; frames(120); collision = 0;
        check("pause_no_tick", n_ticks, 0);
        pauseKey = 0; tick();
        pauseKey = 1; tick();
        check("unpause_state", gameState, S_RUN);
        check("unpause_speed", playerSpeed, 5);
        pauseKey = 0; tick();
`endif

        fuelLsb = 0; fuelMsb = 0; tick();
        check("empty_gameover", gameState, S_GO);
        check("empty_speed", playerSpeed, 0);
        n_ticks = 0; frames(70);
        check("gameover_no_tick", n_ticks, 0);
        fuelLsb = 4'd9; fuelMsb = 4'd9;
        startKey = 1; tick();
        check("restart_cd", gameState, S_CD);
        check("restart_digit", countdownDigit, CNT);
        startKey = 0;
        frames(10);
        reset = 1; tick();
        check("midgame_reset", gameState, S_IDLE);
        reset = 0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
